// File: rtl/t03_timer_pkg.sv
// Shared definitions for the timer scheduler: register map, CTRL bit positions,
// bus FSM states and the per-channel register record.
package t03_timer_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] CMP_OFS     = 2'd0;
  localparam logic [1:0] PERIOD_OFS  = 2'd1;
  localparam logic [1:0] CTRL_OFS    = 2'd2;
  localparam logic [4:0] STATUS_ADDR = 5'd16;
  localparam logic [4:0] ACTIVE_ADDR = 5'd17;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IE_BIT       = 2;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  typedef struct packed {
    logic [BUS_W-1:0] cmp;
    logic [BUS_W-1:0] period;
    logic             en;
    logic             periodic;
    logic             ie;
  } ch_regs_t;

  function automatic logic [BUS_W-1:0] ctrl_word(input ch_regs_t r);
    logic [BUS_W-1:0] w;
    w                    = '0;
    w[CTRL_EN_BIT]       = r.en;
    w[CTRL_PERIODIC_BIT] = r.periodic;
    w[CTRL_IE_BIT]       = r.ie;
    return w;
  endfunction

endpackage

// File: rtl/t03_timer_channel.sv
// One alarm channel: CMP/PERIOD/CTRL registers, wrap-safe expiry compare and
// periodic reload. Bus writes take priority over the hardware reload/disable.
module t03_timer_channel
  import t03_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [CNT_W-1:0] tick_count,
  input  logic             wr_cmp,
  input  logic             wr_period,
  input  logic             wr_ctrl,
  input  logic [BUS_W-1:0] wdata,
  output ch_regs_t         regs,
  output logic             expire
);

  ch_regs_t         regs_q, regs_d;
  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] reload;

  // Sign bit of the modular difference tells whether the target is at or behind now.
  always_comb begin
    delta  = tick_count - regs_q.cmp[CNT_W-1:0];
    expire = adv && regs_q.en && !delta[CNT_W-1];
  end

  always_comb begin
    regs_d = regs_q;
    reload = regs_q.cmp[CNT_W-1:0] + regs_q.period[CNT_W-1:0];
    if (expire) begin
      if (regs_q.periodic && (regs_q.period[CNT_W-1:0] != '0)) begin
        regs_d.cmp = BUS_W'(reload);
      end else begin
        regs_d.en = 1'b0;
      end
    end
    if (wr_cmp) begin
      regs_d.cmp = BUS_W'(wdata[CNT_W-1:0]);
    end
    if (wr_period) begin
      regs_d.period = BUS_W'(wdata[CNT_W-1:0]);
    end
    if (wr_ctrl) begin
      regs_d.en       = wdata[CTRL_EN_BIT];
      regs_d.periodic = wdata[CTRL_PERIODIC_BIT];
      regs_d.ie       = wdata[CTRL_IE_BIT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs = regs_q;

endmodule

// File: rtl/t03_timer_scheduler.sv
// Multi-channel alarm scheduler on the shared tick counter: register bus FSM,
// advance detect, pending STATUS and the registered interrupt priority encoder.
module t03_timer_scheduler
  import t03_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] tick_count,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  output logic             irq,
  output logic [2:0]       irq_id
);

  bus_state_e       bus_state_q, bus_state_d;
  logic [31:0]      bus_rdata_q, bus_rdata_d;
  logic [CNT_W-1:0] prev_tick_q, prev_tick_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic             irq_q, irq_d;
  logic [2:0]       irq_id_q, irq_id_d;

  logic              adv;
  logic              bus_wr;
  logic              is_status, is_active;
  logic [2:0]        ch_sel;
  logic [1:0]        reg_ofs;
  logic [31:0]       rd_value;
  logic [NUM_CH-1:0] w1c, pend;
  logic [NUM_CH-1:0] expire, ie_vec;
  logic [NUM_CH-1:0] wr_cmp, wr_period, wr_ctrl;
  ch_regs_t          regs [NUM_CH];

  assign adv       = (tick_count != prev_tick_q);
  assign bus_wr    = (bus_state_q == BUS_IDLE) && bus_req && bus_we;
  assign is_status = (bus_addr == STATUS_ADDR);
  assign is_active = (bus_addr == ACTIVE_ADDR);
  assign ch_sel    = bus_addr[4:2];
  assign reg_ofs   = bus_addr[1:0];

  // Global addresses win so channels 4..7 never alias STATUS/ACTIVE.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [2:0] IDX = 3'(i);
    logic ch_hit;
    assign ch_hit       = bus_wr && !is_status && !is_active && (ch_sel == IDX);
    assign wr_cmp[i]    = ch_hit && (reg_ofs == CMP_OFS);
    assign wr_period[i] = ch_hit && (reg_ofs == PERIOD_OFS);
    assign wr_ctrl[i]   = ch_hit && (reg_ofs == CTRL_OFS);
    assign ie_vec[i]    = regs[i].ie;

    t03_timer_channel #(.CNT_W(CNT_W)) u_channel (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .tick_count (tick_count),
      .wr_cmp     (wr_cmp[i]),
      .wr_period  (wr_period[i]),
      .wr_ctrl    (wr_ctrl[i]),
      .wdata      (bus_wdata),
      .regs       (regs[i]),
      .expire     (expire[i])
    );
  end

  always_comb begin
    rd_value = '0;
    if (is_status) begin
      rd_value = 32'(status_q);
    end else if (is_active) begin
      rd_value = {irq_q, 28'd0, irq_id_q};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 3'(i)) begin
          case (reg_ofs)
            CMP_OFS:    rd_value = regs[i].cmp;
            PERIOD_OFS: rd_value = regs[i].period;
            CTRL_OFS:   rd_value = ctrl_word(regs[i]);
            default:    rd_value = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus_state_d = bus_state_q;
    bus_rdata_d = bus_rdata_q;
    prev_tick_d = tick_count;
    case (bus_state_q)
      BUS_IDLE: begin
        if (bus_req) begin
          bus_state_d = BUS_RESP;
          bus_rdata_d = bus_we ? '0 : rd_value;
        end
      end
      BUS_RESP: bus_state_d = BUS_IDLE;
      default:  bus_state_d = BUS_IDLE;
    endcase
  end

  // Expiry set is OR'ed after the W1C mask so a same-cycle set survives the clear.
  always_comb begin
    w1c      = (bus_wr && is_status) ? bus_wdata[NUM_CH-1:0] : '0;
    status_d = (status_q & ~w1c) | expire;
    pend     = status_q & ie_vec;
    irq_d    = |pend;
    irq_id_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) irq_id_d = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state_q <= BUS_IDLE;
      bus_rdata_q <= '0;
      prev_tick_q <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      bus_rdata_q <= bus_rdata_d;
      prev_tick_q <= prev_tick_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign bus_ack   = (bus_state_q == BUS_RESP);
  assign bus_rdata = bus_rdata_q;
  assign irq       = irq_q;
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_t03_timer_scheduler.sv
// Self-checking bench for the timer scheduler: a register table plus hand-written
// expiry, wrap, collision, bus-timing and reset sequences; reads go through a scoreboard.
module tb_t03_timer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tick_count;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        irq;
  logic [2:0]  irq_id;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  vec_t     vecs[14];
  int       n_compared   = 0;
  int       n_mismatched = 0;

  t03_timer_scheduler #(.NUM_CH(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_count (tick_count),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Called on a negedge; returns two negedges after the ack so the FSM is idle again.
  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input string name);
    int       waited;
    sb_item_t item;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    if (!we) sb_q.push_back('{name, exp});
    waited = 0;
    do begin
      @(negedge clk);
      bus_req = 1'b0;
      waited++;
    end while (!bus_ack && waited < 8);
    checkOutput({name, "_latency"}, 32'(waited), 32'd1);
    if (!we) begin
      item = sb_q.pop_front();
      if (bus_ack) checkOutput(item.name, bus_rdata, item.exp);
    end
    @(negedge clk);
  endtask

  task automatic set_tick(input logic [31:0] t, input int hold);
    tick_count = t;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tick_count = '0;
    bus_req    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'h0C, 32'h13579BDF, 32'h0,        "w_ch3_cmp"};
    vecs[1]  = '{1'b1, 5'h0D, 32'hDEADBEEF, 32'h0,        "w_ch3_period"};
    vecs[2]  = '{1'b1, 5'h0E, 32'hFFFFFFFA, 32'h0,        "w_ch3_ctrl"};
    vecs[3]  = '{1'b1, 5'h03, 32'h00001234, 32'h0,        "w_unmapped_ofs3"};
    vecs[4]  = '{1'b1, 5'h12, 32'h0000FFFF, 32'h0,        "w_ch4_ctrl"};
    vecs[5]  = '{1'b0, 5'h0C, 32'h0,        32'h13579BDF, "r_ch3_cmp"};
    vecs[6]  = '{1'b0, 5'h0D, 32'h0,        32'hDEADBEEF, "r_ch3_period"};
    vecs[7]  = '{1'b0, 5'h0E, 32'h0,        32'h00000002, "r_ch3_ctrl"};
    vecs[8]  = '{1'b0, 5'h03, 32'h0,        32'h0,        "r_unmapped_ofs3"};
    vecs[9]  = '{1'b0, 5'h14, 32'h0,        32'h0,        "r_addr20"};
    vecs[10] = '{1'b0, 5'h10, 32'h0,        32'h0,        "r_status_reset"};
    vecs[11] = '{1'b0, 5'h11, 32'h0,        32'h0,        "r_active_reset"};
    vecs[12] = '{1'b0, 5'h00, 32'h0,        32'h0,        "r_ch0_cmp_reset"};
    vecs[13] = '{1'b0, 5'h1F, 32'h0,        32'h0,        "r_addr31"};

    rst        = 1'b1;
    tick_count = '0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    @(negedge clk);
    checkOutput("reset_ack",    32'(bus_ack), 32'd0);
    checkOutput("reset_rdata",  bus_rdata,    32'd0);
    checkOutput("reset_irq",    32'(irq),     32'd0);
    checkOutput("reset_irq_id", 32'(irq_id),  32'd0);
    do_reset();

    $display("[TB] register table");
    foreach (vecs[i]) applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);

    $display("[TB] one-shot");
    do_reset();
    applyStimulus(1, 5'd0, 32'd5, 0, "os_w_cmp");
    applyStimulus(1, 5'd2, 32'b101, 0, "os_w_ctrl");
    set_tick(32'd4, 3);
    applyStimulus(0, 5'd16, 0, 32'h0, "os_status_t4");
    set_tick(32'd5, 3);
    checkOutput("os_irq", 32'(irq), 32'd1);
    checkOutput("os_irq_id", 32'(irq_id), 32'd0);
    applyStimulus(0, 5'd16, 0, 32'h1, "os_status_t5");
    applyStimulus(0, 5'd17, 0, 32'h80000000, "os_active");
    applyStimulus(0, 5'd2, 0, 32'b100, "os_ctrl_en_cleared");
    applyStimulus(1, 5'd16, 32'h1, 0, "os_w1c");
    @(negedge clk);
    checkOutput("os_irq_cleared", 32'(irq), 32'd0);
    applyStimulus(0, 5'd16, 0, 32'h0, "os_status_cleared");

    $display("[TB] periodic");
    do_reset();
    applyStimulus(1, 5'd4, 32'd10, 0, "per_w_cmp");
    applyStimulus(1, 5'd5, 32'd3, 0, "per_w_period");
    applyStimulus(1, 5'd6, 32'b111, 0, "per_w_ctrl");
    set_tick(32'd9, 3);
    applyStimulus(0, 5'd16, 0, 32'h0, "per_status_t9");
    set_tick(32'd10, 3);
    applyStimulus(0, 5'd16, 0, 32'h2, "per_status_t10");
    applyStimulus(1, 5'd16, 32'h2, 0, "per_w1c_t10");
    repeat (100) @(negedge clk);
    applyStimulus(0, 5'd16, 0, 32'h0, "per_status_hold");
    applyStimulus(0, 5'd4, 0, 32'd13, "per_cmp_13");
    for (int t = 11; t <= 16; t++) begin
      set_tick(32'(t), 3);
      applyStimulus(0, 5'd16, 0, (t == 13 || t == 16) ? 32'h2 : 32'h0, $sformatf("per_status_t%0d", t));
      if (t == 13 || t == 16) applyStimulus(1, 5'd16, 32'h2, 0, "per_w1c");
    end
    applyStimulus(0, 5'd4, 0, 32'd19, "per_cmp_19");

    $display("[TB] late compare");
    do_reset();
    set_tick(32'd50, 3);
    applyStimulus(1, 5'd0, 32'd2, 0, "late_w_cmp");
    applyStimulus(1, 5'd2, 32'b001, 0, "late_w_ctrl");
    applyStimulus(0, 5'd16, 0, 32'h0, "late_status_before");
    set_tick(32'd51, 3);
    applyStimulus(0, 5'd16, 0, 32'h1, "late_status_after");
    applyStimulus(0, 5'd2, 0, 32'h0, "late_ctrl");

    $display("[TB] wrap");
    do_reset();
    set_tick(32'hFFFFFFFE, 3);
    applyStimulus(1, 5'd8, 32'h1, 0, "wrap_w_cmp");
    applyStimulus(1, 5'd10, 32'b101, 0, "wrap_w_ctrl");
    set_tick(32'hFFFFFFFF, 3);
    applyStimulus(0, 5'd16, 0, 32'h0, "wrap_status_ffffffff");
    set_tick(32'h0, 3);
    applyStimulus(0, 5'd16, 0, 32'h0, "wrap_status_0");
    set_tick(32'h1, 3);
    applyStimulus(0, 5'd16, 0, 32'h4, "wrap_status_1");
    checkOutput("wrap_irq_id", 32'(irq_id), 32'd2);

    $display("[TB] priority and collisions");
    do_reset();
    applyStimulus(1, 5'd8, 32'd20, 0, "pri_w_ch2_cmp");
    applyStimulus(1, 5'd9, 32'd1, 0, "pri_w_ch2_period");
    applyStimulus(1, 5'd10, 32'b111, 0, "pri_w_ch2_ctrl");
    applyStimulus(1, 5'd12, 32'd20, 0, "pri_w_ch3_cmp");
    applyStimulus(1, 5'd14, 32'b101, 0, "pri_w_ch3_ctrl");
    set_tick(32'd20, 3);
    checkOutput("pri_irq_id", 32'(irq_id), 32'd2);
    applyStimulus(0, 5'd16, 0, 32'hC, "pri_status");
    applyStimulus(0, 5'd17, 0, 32'h80000002, "pri_active");
    tick_count = 32'd21;
    applyStimulus(1, 5'd16, 32'h4, 0, "col_w1c_vs_expire");
    applyStimulus(0, 5'd16, 0, 32'hC, "col_status_set_wins");
    applyStimulus(1, 5'd16, 32'h4, 0, "col_w1c_plain");
    @(negedge clk);
    checkOutput("col_irq_id_3", 32'(irq_id), 32'd3);
    applyStimulus(0, 5'd16, 0, 32'h8, "col_status_8");
    tick_count = 32'd22;
    applyStimulus(1, 5'd8, 32'd100, 0, "col_w_cmp_vs_expire");
    applyStimulus(0, 5'd16, 0, 32'hC, "col_cmp_pending_set");
    applyStimulus(0, 5'd8, 0, 32'd100, "col_cmp_write_wins");
    checkOutput("col_irq_id_2", 32'(irq_id), 32'd2);

    $display("[TB] bus timing");
    do_reset();
    applyStimulus(1, 5'd0, 32'h55, 0, "bt_w_cmp");
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 5'd0;
    @(negedge clk);
    checkOutput("bt_ack_after_1", 32'(bus_ack), 32'd1);
    checkOutput("bt_rdata", bus_rdata, 32'h55);
    bus_we    = 1'b1;
    bus_wdata = 32'hBAD;
    @(negedge clk);
    checkOutput("bt_ack_one_cycle", 32'(bus_ack), 32'd0);
    bus_req = 1'b0;
    @(negedge clk);
    applyStimulus(0, 5'd0, 0, 32'h55, "bt_req_in_resp_ignored");

    $display("[TB] reset mid-transaction");
    do_reset();
    applyStimulus(1, 5'd0, 32'd5, 0, "rm_w_cmp");
    applyStimulus(1, 5'd1, 32'd2, 0, "rm_w_period");
    applyStimulus(1, 5'd2, 32'b111, 0, "rm_w_ctrl");
    set_tick(32'd5, 3);
    checkOutput("rm_irq_before", 32'(irq), 32'd1);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 5'd16;
    @(negedge clk);
    bus_req = 1'b0;
    checkOutput("rm_ack_before", 32'(bus_ack), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rm_ack_dropped", 32'(bus_ack), 32'd0);
    checkOutput("rm_irq_dropped", 32'(irq), 32'd0);
    checkOutput("rm_rdata_cleared", bus_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_tick(32'd7, 3);
    set_tick(32'd9, 3);
    checkOutput("rm_irq_after", 32'(irq), 32'd0);
    applyStimulus(0, 5'd16, 0, 32'h0, "rm_status_after");
    applyStimulus(0, 5'd2, 0, 32'h0, "rm_ctrl_after");
    applyStimulus(0, 5'd0, 0, 32'h0, "rm_cmp_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
